// File: rtl/wide_add_seq.sv
// rtl/wide_add_seq.sv - word-serial wide add/subtract sequencer sharing one 32-bit CLA
// Operands are consumed least-significant word first; the carry chains between words through carry_q.

module cla32 (
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [8:0]  gc;
  logic [7:0]  gg;
  logic [7:0]  gp;

  assign g = num1 & num2;
  assign p = num1 ^ num2;

  // Group generate/propagate over 4-bit nibbles gives the lookahead carry into each nibble.
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k] = gc[k];
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
    c[32] = gc[8];
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];

endmodule

module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  busy
);

  localparam int W  = 32 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  state_t        state_d;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [IW-1:0] idx;
  logic [31:0]   a_w   [WORDS];
  logic [31:0]   b_w   [WORDS];
  logic [31:0]   res_w [WORDS];
  logic [31:0]   word_sum;
  logic          word_cout;

  for (genvar i = 0; i < WORDS; i++) begin : g_word
    assign a_w[i] = a_q[32*i +: 32];
    assign b_w[i] = b_q[32*i +: 32];
    assign result[32*i +: 32] = res_w[i];
  end

  cla32 u_cla (
    .num1 (a_w[idx]),
    .num2 (b_w[idx]),
    .cin  (carry_q),
    .sum  (word_sum),
    .cout (word_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtract is A + ~B + 1: B is inverted at capture and the +1 rides in as the first carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < WORDS; i++) res_w[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= op_b ^ {W{sub}};
            carry_q <= sub;
            idx     <= '0;
          end
        end
        RUN: begin
          res_w[idx] <= word_sum;
          carry_q    <= word_cout;
          if (idx == LAST) begin
            carry_out <= word_cout;
            overflow  <= (a_q[W-1] == b_q[W-1]) && (word_sum[31] != a_q[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// tb/tb_wide_add_seq.sv - self-checking bench for wide_add_seq against a wide-arithmetic model
// Directed corner cases pin the model with literals; random traffic runs under random backpressure.

module tb_wide_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    int           e;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           n_done = 0;
  bit           seen = 1'b0;
  bit           rand_rdy = 1'b0;
  logic [W-1:0] last_r;
  logic         last_c;
  logic         last_v;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int e);
    exp_t       x;
    logic [W:0] wide;
    if (s) begin
      x.r = a - b;
      x.c = (a >= b);
      x.v = (a[W-1] != b[W-1]) && (x.r[W-1] != a[W-1]);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      x.r  = wide[W-1:0];
      x.c  = wide[W];
      x.v  = (a[W-1] == b[W-1]) && (x.r[W-1] != a[W-1]);
    end
    x.e = e;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      seen = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious out_valid", W'(out_valid), W'(0));
        end else begin
          if (!seen) begin
            chk("latency", W'(cyc), W'(q[0].e + WORDS));
            seen = 1'b1;
          end
          chk("result", result, q[0].r);
          chk("carry_out", W'(carry_out), W'(q[0].c));
          chk("overflow", W'(overflow), W'(q[0].v));
          chk("in_ready in done", W'(in_ready), W'(0));
          chk("busy in done", W'(busy), W'(0));
          if (out_ready) begin
            last_r = result;
            last_c = carry_out;
            last_v = overflow;
            void'(q.pop_front());
            seen = 1'b0;
            n_done++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(op_a, op_b, sub, cyc + 1));
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub = s;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    #1;
    in_valid = 1'b0;
    if (!ok) chk("accept timeout", W'(ok), W'(1));
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (n_done < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n_done < target) chk("completion timeout", W'(n_done), W'(target));
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int target;
    target = n_done + 1;
    send(a, b, s);
    wait_done(target);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " out_valid"}, W'(out_valid), W'(0));
    chk({tag, " in_ready"}, W'(in_ready), W'(1));
    chk({tag, " busy"}, W'(busy), W'(0));
    chk({tag, " result"}, result, W'(0));
    chk({tag, " carry_out"}, W'(carry_out), W'(0));
    chk({tag, " overflow"}, W'(overflow), W'(0));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] msb;
    logic [W-1:0] sp [6];
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           target;
    int           n;

    ones = '1;
    msb  = {1'b1, {(W-1){1'b0}}};
    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    sub = 1'b0;
    out_ready = 1'b1;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run(128'hFFFFFFFF, 128'd1, 1'b0);
    chk("ripple result", last_r, 128'h1_00000000);
    chk("ripple carry", W'(last_c), W'(0));
    chk("ripple ovf", W'(last_v), W'(0));

    run(ones, 128'd1, 1'b0);
    chk("wrap result", last_r, W'(0));
    chk("wrap carry", W'(last_c), W'(1));
    chk("wrap ovf", W'(last_v), W'(0));

    run(128'd0, 128'd1, 1'b1);
    chk("borrow result", last_r, ones);
    chk("borrow carry", W'(last_c), W'(0));
    chk("borrow ovf", W'(last_v), W'(0));

    run(128'd5, 128'd3, 1'b1);
    chk("5-3 result", last_r, 128'd2);
    chk("5-3 carry", W'(last_c), W'(1));

    run(~msb, 128'd1, 1'b0);
    chk("pos ovf result", last_r, msb);
    chk("pos ovf flag", W'(last_v), W'(1));
    chk("pos ovf carry", W'(last_c), W'(0));

    run(msb, 128'd1, 1'b1);
    chk("neg ovf result", last_r, ~msb);
    chk("neg ovf flag", W'(last_v), W'(1));

    out_ready = 1'b0;
    target = n_done + 2;
    send(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 128'h1111_1111_2222_2222_3333_3333_4444_4444, 1'b0);
    in_valid = 1'b1;
    op_a = 128'd3;
    op_b = 128'd4;
    sub = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    chk("bp reached done", W'(out_valid), W'(1));
    repeat (5) begin
      chk("bp out_valid held", W'(out_valid), W'(1));
      chk("bp in_ready low", W'(in_ready), W'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp idle after release", W'(in_ready), W'(1));
    chk("bp out_valid dropped", W'(out_valid), W'(0));
    @(posedge clk);
    #1;
    chk("bp pending accepted", W'(busy), W'(1));
    in_valid = 1'b0;
    wait_done(target);
    chk("bp pending result", last_r, 128'd7);

    send({4{32'h11111111}}, {4{32'h22222222}}, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-run reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(128'd3, 128'd4, 1'b0);
    chk("post reset result", last_r, 128'd7);

    sp[0] = '0;
    sp[1] = ones;
    sp[2] = msb;
    sp[3] = ~msb;
    sp[4] = 128'd1;
    sp[5] = 128'hFFFFFFFF;
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = sp[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) b = sp[$urandom_range(0, 5)];
      send(a, b, 1'($urandom_range(0, 1)));
    end
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    rand_rdy = 1'b0;
    #2 out_ready = 1'b1;
    chk("drain", W'(q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle wide-integer add/subtract sequencer built around a single shared `cla32` instance. It accepts two `32*WORDS`-bit operands through a valid/ready handshake and processes them one 32-bit word per cycle, least-significant word first. The carry from each word feeds the next word, and the block reports the full-width result, carry-out and signed overflow through a second valid/ready handshake. It sits between the execution-unit operand buffers and the writeback path, letting wide (bignum/crypto) operations reuse the 32-bit adder instead of a dedicated wide adder.

## Interface
- `WORDS`, default 4: number of 32-bit words per operand; must be ≥1. The default gives a 128-bit datapath.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  block can accept; equals (state == IDLE).
- `op_a`  in  32*WORDS  operand A.
- `op_b`  in  32*WORDS  operand B.
- `sub`  in  1  1 = compute A − B; 0 = compute A + B.
- `out_valid`  out  1  result valid; equals (state == DONE).
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  32*WORDS  registered sum or difference.
- `carry_out`  out  1  final carry out of the top word; for subtract, 1 = no borrow.
- `overflow`  out  1  two's-complement signed overflow of the full-width operation.
- `busy`  out  1  high in RUN.

## Operation
- Internal registers:
  - `a_q`, `b_q` (B pre-inverted when `sub` = 1).
  - `carry_q`.
  - `idx` (width `$clog2(WORDS)`, minimum 1).
  - `result`, `carry_out`, `overflow`.
- One `cla32` instance, wired as follows:
  - `num1` = word `idx` of `a_q`.
  - `num2` = word `idx` of `b_q`.
  - `cin` = `carry_q`.
- FSM, states IDLE → RUN → DONE:
  - IDLE: when `in_valid` && `in_ready`, latch `op_a` into `a_q` and `op_b ^ {32*WORDS{sub}}` into `b_q`. Set `carry_q` ← `sub` and `idx` ← 0, then go to RUN.
  - RUN, every cycle:
    - Write the adder sum into result word `idx`.
    - Set `carry_q` ← the adder carry out.
    - If `idx` == WORDS−1: set `carry_out` ← the adder carry out, compute `overflow`, and go to DONE.
    - Otherwise increment `idx`.
  - DONE: hold `result`, `carry_out` and `overflow`. When `out_ready` = 1, go to IDLE. `result` keeps its value in IDLE until the next RUN overwrites it word by word.
- Overflow = (`a_q`[MSB] == `b_q`[MSB]) && (top-word sum[31] != `a_q`[MSB]), using the inverted B for subtract.
- `in_valid` is ignored outside IDLE; the block has no queueing. `out_ready` is ignored outside DONE.
- Arithmetic is modulo 2^(32*WORDS). The `carry_out` of the top word is the only carry visible to the consumer.

## Timing
- Reset (async assert, `rst_n` = 0):
  - State = IDLE and `idx` = 0.
  - `carry_q`, `result`, `carry_out` and `overflow` = 0.
  - `out_valid` = 0, `busy` = 0, `in_ready` = 1.
  - These values take effect immediately, without waiting for a clock edge.
- Reset during RUN or DONE aborts the operation and discards it. No `out_valid` is produced for it.
- Deassertion of reset is synchronised by the top level. The first edge with `rst_n` = 1 may accept a request.
- Latency:
  - Acceptance edge E.
  - RUN occupies edges E+1 … E+WORDS.
  - `out_valid` = 1 in the cycle after edge E+WORDS.
- Throughput: with `out_ready` tied high, one operation per WORDS+2 cycles (accept, WORDS RUN cycles, DONE).
- Output stability: `result`, `carry_out` and `overflow` are stable for the whole time `out_valid` = 1. `in_ready` = 0 throughout RUN and DONE.
- WORDS = 1: RUN lasts one cycle, and `idx` stays 0 throughout.
- Adder path: the combinational path is register → `cla32` → register only. No handshake input feeds the adder combinationally.

## Test plan
All cases use WORDS = 4.
- Carry ripple across words: A = 0x0000…0000_FFFFFFFF, B = 1, add → `result` = 0x0000…0001_00000000, `carry_out` = 0, `overflow` = 0. `out_valid` must rise exactly 4 edges after acceptance.
- Full wrap: A = all ones, B = 1, add → `result` = 0, `carry_out` = 1, `overflow` = 0.
- Subtract with borrow: A = 0, B = 1, `sub` = 1 → `result` = all ones, `carry_out` = 0, `overflow` = 0. Repeat with A = 5, B = 3 → `result` = 2, `carry_out` = 1.
- Signed overflow: A = 0x7FFF…FFFF, B = 1, add → `result` = 0x8000…0000, `overflow` = 1, `carry_out` = 0. Then A = 0x8000…0000, B = 1, `sub` = 1 → `result` = 0x7FFF…FFFF, `overflow` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE while `in_valid` = 1 with new operands → `out_valid`, `result` and `in_ready` = 0 must stay stable, and no new request is accepted. Release `out_ready` → IDLE on the next edge, and the pending request is accepted on the following edge.
- Reset mid-operation: assert `rst_n` = 0 while `idx` = 2 in RUN → all outputs take reset values immediately. After release, a new add of 3 + 4 must complete with `result` = 7 and no spurious `out_valid` from the aborted operation.
